// File: rtl/regbus_pkg.sv
// Shared definitions for the peripheral register file and its access-port arbiter:
// sequencer states, legality masks and the register map.
package regbus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  // Bit n set means word address n may be written / read.
  localparam logic [15:0] WR_OK_MASK = 16'h13F4;
  localparam logic [15:0] RD_OK_MASK = 16'h1FFF;

  localparam logic [3:0] ADDR_ID        = 4'h0;
  localparam logic [3:0] ADDR_STATUS    = 4'h1;
  localparam logic [3:0] ADDR_CTRL      = 4'h2;
  localparam logic [3:0] ADDR_IRQ_STAT  = 4'h3;
  localparam logic [3:0] ADDR_IRQ_EN    = 4'h4;
  localparam logic [3:0] ADDR_TIMER_LD  = 4'h5;
  localparam logic [3:0] ADDR_SCRATCH   = 4'h6;
  localparam logic [3:0] ADDR_GPIO_OUT  = 4'h7;
  localparam logic [3:0] ADDR_GPIO_DIR  = 4'h8;
  localparam logic [3:0] ADDR_GPIO_IE   = 4'h9;
  localparam logic [3:0] ADDR_GPIO_IN   = 4'hA;
  localparam logic [3:0] ADDR_TIMER_VAL = 4'hB;
  localparam logic [3:0] ADDR_DBG_CTRL  = 4'hC;

  function automatic logic access_err(input logic [3:0] addr, input logic r_wn);
    return r_wn ? !RD_OK_MASK[addr] : !WR_OK_MASK[addr];
  endfunction

endpackage

// File: rtl/regbus_arbiter.sv
// Round-robin arbiter and 4-cycle sequencer (IDLE/ISSUE/WAIT/ACK) placing the CPU (m0) and
// debug (m1) masters onto the register file's single port with a registered read.
module regbus_arbiter
  import regbus_pkg::*;
#(
  parameter logic       RR_INIT   = 1'b0,
  parameter logic [3:0] IDLE_ADDR = ADDR_ID
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic [3:0]  m0_addr,
  input  logic        m0_r_wn,
  input  logic [3:0]  m0_wben,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [3:0]  m1_addr,
  input  logic        m1_r_wn,
  input  logic [3:0]  m1_wben,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [3:0]  reg_addr,
  output logic        reg_r_wn,
  output logic [3:0]  reg_wben,
  output logic [31:0] reg_wdata,
  input  logic [31:0] reg_rdata,
  output logic        busy
);

  state_t r_state;
  logic   r_ptr;
  logic   r_id;
  logic   r_r_wn;
  logic   r_err;

  logic        w_any;
  logic        w_win;
  logic [3:0]  w_addr;
  logic        w_r_wn;
  logic [3:0]  w_wben;
  logic [31:0] w_wdata;
  logic        w_err;
  logic [31:0] w_rdata_cap;

  // Pointer only matters on a tie; a lone requester always wins.
  assign w_any   = m0_req | m1_req;
  assign w_win   = (m0_req & m1_req) ? r_ptr : m1_req;
  assign w_addr  = w_win ? m1_addr  : m0_addr;
  assign w_r_wn  = w_win ? m1_r_wn  : m0_r_wn;
  assign w_wben  = w_win ? m1_wben  : m0_wben;
  assign w_wdata = w_win ? m1_wdata : m0_wdata;
  assign w_err   = access_err(w_addr, w_r_wn);

  assign w_rdata_cap = (r_err || !r_r_wn) ? 32'h0 : reg_rdata;

  // Port registers double as the latched payload; ack/err/rdata registers are the holding registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_ptr     <= RR_INIT;
      r_id      <= 1'b0;
      r_r_wn    <= 1'b1;
      r_err     <= 1'b0;
      reg_addr  <= IDLE_ADDR;
      reg_r_wn  <= 1'b1;
      reg_wben  <= 4'h0;
      reg_wdata <= 32'h0;
      m0_ack    <= 1'b0;
      m0_err    <= 1'b0;
      m0_rdata  <= 32'h0;
      m1_ack    <= 1'b0;
      m1_err    <= 1'b0;
      m1_rdata  <= 32'h0;
      busy      <= 1'b0;
    end else begin
      m0_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= 32'h0;
      m1_ack   <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= 32'h0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_id    <= w_win;
            r_r_wn  <= w_r_wn;
            r_err   <= w_err;
            r_ptr   <= ~w_win;
            busy    <= 1'b1;
            r_state <= ISSUE;
            if (!w_err) begin
              reg_addr  <= w_addr;
              reg_r_wn  <= w_r_wn;
              reg_wben  <= w_r_wn ? 4'h0 : w_wben;
              reg_wdata <= w_r_wn ? 32'h0 : w_wdata;
            end
          end
        end
        ISSUE: begin
          reg_addr  <= IDLE_ADDR;
          reg_r_wn  <= 1'b1;
          reg_wben  <= 4'h0;
          reg_wdata <= 32'h0;
          r_state   <= WAIT;
        end
        WAIT: begin
          if (r_id) begin
            m1_ack   <= 1'b1;
            m1_err   <= r_err;
            m1_rdata <= w_rdata_cap;
          end else begin
            m0_ack   <= 1'b1;
            m0_err   <= r_err;
            m0_rdata <= w_rdata_cap;
          end
          r_state <= ACK;
        end
        ACK: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/regbus_arbiter.md
# regbus_arbiter

Two-requester arbiter and sequencer for the peripheral register file's single access port. It sits between the CPU load/store path (m0) and the debug/host path (m1) on one side and the register file on the other. It grants the port round-robin, screens illegal accesses, and sequences each access through the register file's one-cycle registered read. It returns read data and a per-access ack/err.

## Interface
Parameters:
- RR_INIT, default 0: master that has priority after reset (0 = m0, 1 = m1).
- IDLE_ADDR, default 4'h0: address driven on the port while idle. This address must be a side-effect-free read.

Ports:
- clk  in  1  master clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- m0_req  in  1  m0 access request; hold high with payload stable until m0_ack.
- m0_addr  in  4  [5:2] word address.
- m0_r_wn  in  1  1 = read, 0 = write.
- m0_wben  in  4  write byte enables.
- m0_wdata  in  32  write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_err  out  1  valid with m0_ack; access rejected.
- m0_rdata  out  32  read data, valid with m0_ack.
- m1_req, m1_addr, m1_r_wn, m1_wben, m1_wdata, m1_ack, m1_err, m1_rdata: same as m0.
- reg_addr  out  4  register file address.
- reg_r_wn  out  1  register file read/write-not.
- reg_wben  out  4  register file byte enables.
- reg_wdata  out  32  register file write data.
- reg_rdata  in  32  register file read data; registered, valid the cycle after the read is issued.
- busy  out  1  high in any state other than IDLE.

## Operation
- The port has no idle encoding. Idle therefore means reg_r_wn=1, reg_wben=0, reg_addr=IDLE_ADDR, reg_wdata=0.
- Legality:
  - Writes are legal only to addresses in WR_OK_MASK (2,4,5,6,7,8,9,12).
  - Reads are legal only to addresses in RD_OK_MASK (0–12).
  - An illegal access is not forwarded: the port stays idle. The access completes with err=1 and rdata=0, with the same latency as a legal access.
- Arbitration happens in IDLE only.
  - If exactly one req is high, that master wins.
  - If both are high, the master named by the priority pointer wins. After every grant, the pointer moves to the other master.
- FSM:
  - IDLE: when any req is high, latch the winner's payload and id. Compute err. Go to ISSUE.
  - ISSUE: drive the port from the latched payload, or idle values if err. The register file acts on the closing edge. Go to WAIT.
  - WAIT: port idle. At the closing edge, capture reg_rdata into the holding register, or 0 if err or write. Go to ACK.
  - ACK: assert the winner's ack for one cycle, with err and rdata from the holding registers. The other master's ack and err stay 0. Go to IDLE.
- wben=0 on a legal write is forwarded as a harmless no-op. err=0.
- A req that drops before its ack (a protocol violation) does not abort the access: the access completes and the ack is still issued.
- reset_n low, at any time including mid-access:
  - FSM goes to IDLE.
  - Port returns to idle values.
  - All ack and err outputs go to 0; rdata outputs and holding registers go to 0.
  - Pointer returns to RR_INIT; busy goes to 0.
  - An access cut off by reset is dropped without an ack. A write whose ISSUE edge already occurred is committed.

## Timing
- All outputs are registered.
- req sampled high at edge E0 gives: port driven in cycle E0–E1, reg_rdata captured at E2, ack high in cycle E2–E3.
- Fixed 4-cycle occupancy per access, including the IDLE arbitration cycle. One master streaming back-to-back reaches 1 access per 4 cycles.
- With both masters requesting continuously, grants alternate strictly. Neither master waits more than 4 cycles beyond its own access time.
- The master must not change its payload while req is high and ack has not yet been seen. It may keep req high after ack to request the next access; that request is re-arbitrated in the following IDLE cycle.

## Structure
- Shared package regbus_pkg: state enum (IDLE, ISSUE, WAIT, ACK), WR_OK_MASK = 16'h13F4, RD_OK_MASK = 16'h1FFF, and the address constants for the register map. The register file and its testbench use the same package.
- Single module, no sub-modules. The 2-way round-robin pick is a few lines and does not need its own block.

## Test plan
- m0 read of address 0 with the register file returning 32'h48524a44: ack at E0+3, rdata=32'h48524a44, err=0. Port driven only in the ISSUE cycle.
- m1 write to address 6 with wdata 32'hDEADBEEF, wben 4'b0011: exactly one ISSUE cycle with reg_r_wn=0, reg_wben=4'b0011. A following m0 read of address 6 returns 32'h0000BEEF.
- m0 write to address 1 (read-only) and m1 read of address 14: both ack with err=1, rdata=0. The port stays at idle values throughout.
- Both reqs held high for 8 accesses after reset (RR_INIT=0): grants go m0, m1, m0, m1, …, each ack spaced 4 cycles apart.
- reset_n pulsed low in the WAIT cycle of an m0 read: no m0_ack. Outputs and pointer return to reset values, and a new request is serviced normally.
